// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined adder/subtractor. Each pipeline stage adds one
// SLICE-bit chunk of the operands and passes its carry to the next stage.
// Subtraction is done as a + ~b + ~cin; the final carry is inverted so that
// cout reads as a borrow.
//
// Handshake: a beat moves into the block on a rising edge where
// in_valid && in_ready. A result moves out on a rising edge where
// out_valid && out_ready. The pipeline stalls as a whole:
// advance = !out_valid || out_ready. When advance is low, every stage holds
// its contents. in_ready is advance gated by !rst, so beats offered during
// reset are never taken.
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = (SLICE > 0) ? (WIDTH / SLICE) : 1;

  // Refuse to build a pipeline that would leave a partial slice.
  if (SLICE <= 0 || WIDTH <= 0 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("pipe_addsub: WIDTH must be a non-zero multiple of SLICE");
  end

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SLICE;      // lowest bit handled by this stage
    localparam int RW  = LO + SLICE;     // result bits complete after this stage
    localparam int UPW = WIDTH - RW;     // operand bits still to be added

    logic [SLICE-1:0] sa;                // slice-k operand A
    logic [SLICE-1:0] sb;                // slice-k operand B, already inverted for sub
    logic             ci;                // carry into this slice
    logic             si;                // sub flag of the beat in this slot
    logic             vi;                // valid of the beat in this slot
    logic [SLICE:0]   ssum;              // slice sum with carry-out on top
    logic [RW-1:0]    res_d;

    logic             v_q;
    logic             c_q;
    logic             sub_q;
    logic [RW-1:0]    res_q;

    if (k == 0) begin : g_src
      // Stage 0 takes its slice straight from the ports; inverting b and cin
      // here turns the whole pipeline into a plain adder for the rest.
      assign sa    = a[SLICE-1:0];
      assign sb    = b[SLICE-1:0] ^ {SLICE{sub}};
      assign ci    = cin ^ sub;
      assign si    = sub;
      assign vi    = in_valid;
      assign res_d = ssum[SLICE-1:0];
    end else begin : g_src
      // Later stages consume the lowest unprocessed slice of the previous
      // stage and extend its finished result by one slice.
      assign sa    = g_stage[k-1].g_up.a_q[SLICE-1:0];
      assign sb    = g_stage[k-1].g_up.b_q[SLICE-1:0];
      assign ci    = g_stage[k-1].c_q;
      assign si    = g_stage[k-1].sub_q;
      assign vi    = g_stage[k-1].v_q;
      assign res_d = {ssum[SLICE-1:0], g_stage[k-1].res_q};
    end

    assign ssum = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, ci};

    // Stage register: valid, finished low result, carry and sub flag.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sub_q <= 1'b0;
        res_q <= '0;
      end else if (advance) begin
        v_q   <= vi;
        c_q   <= ssum[SLICE];
        sub_q <= si;
        res_q <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_up
      logic [UPW-1:0] a_q;
      logic [UPW-1:0] b_q;
      logic [UPW-1:0] a_d;
      logic [UPW-1:0] b_d;

      if (k == 0) begin : g_ud
        assign a_d = a[WIDTH-1:SLICE];
        assign b_d = b[WIDTH-1:SLICE] ^ {UPW{sub}};
      end else begin : g_ud
        assign a_d = g_stage[k-1].g_up.a_q[WIDTH-LO-1:SLICE];
        assign b_d = g_stage[k-1].g_up.b_q[WIDTH-LO-1:SLICE];
      end

      // Carry the not-yet-added upper operand slices along with the beat.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      // Signed overflow: same operand signs, result sign differs.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (sa[SLICE-1] == sb[SLICE-1]) && (ssum[SLICE-1] != sa[SLICE-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].res_q;
  assign cout      = g_stage[STAGES-1].c_q ^ g_stage[STAGES-1].sub_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub (WIDTH=16, SLICE=4, four stages).
module tb_pipe_addsub;

  localparam int W  = 16;
  localparam int SL = 4;
  localparam int ST = W / SL;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  pipe_addsub #(.WIDTH(W), .SLICE(SL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic armed = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Result packed as {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c, input logic s);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         co;
    logic         o;
    if (!s) begin
      full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      r    = full[W-1:0];
      co   = full[W];
      o    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r    = x - y - W'(c);
      co   = ({1'b0, x} < ({1'b0, y} + (W+1)'(c)));
      o    = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {o, co, r};
  endfunction

  // In-flight beats: expected result and how many pipeline advances each has seen.
  logic [W+1:0] exp_q[$];
  int           age_q[$];

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic exp_v;
    logic exp_adv;
    if (armed) begin
      exp_v = (age_q.size() > 0) && (age_q[0] == ST);
      check("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v)
        check("result", 32'({ovf, cout, sum}), 32'(exp_q[0]));
      exp_adv = !exp_v || out_ready;
      check("in_ready", 32'(in_ready), 32'(exp_adv && !rst));
      if (rst) begin
        exp_q.delete();
        age_q.delete();
      end else if (exp_adv) begin
        if (exp_v) begin
          void'(exp_q.pop_front());
          void'(age_q.pop_front());
        end
        foreach (age_q[i]) age_q[i]++;
        if (in_valid) begin
          exp_q.push_back(ref_calc(a, b, cin, sub));
          age_q.push_back(1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one beat from posedge+1 until it is taken; returns the cycle in
  // which it was taken. Leaves the bench at posedge+1 with in_valid low.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ts, output int acc);
    logic ok;
    ok       = 1'b0;
    acc      = -1;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    cin      = tc;
    sub      = ts;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) acc = cyc;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; returns the cycle it was seen, at a negedge.
  task automatic wait_out(output int oc);
    logic seen;
    seen = 1'b0;
    oc   = -1;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        oc   = cyc;
      end
    end
    check("wait_out_timeout", 32'(seen), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  int acc;
  int oc;
  int lows;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;          // offered during reset, must be discarded
    a         = 16'h5555;
    b         = 16'h2222;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    armed = 1'b1;
    idle(2);
    // Reset state, hand-written.
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(2);

    // Pin the model to hand-computed values.
    check("pin_add_wrap", 32'(ref_calc(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h1_0000);
    check("pin_add_ovf",  32'(ref_calc(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'h2_8000);
    check("pin_sub_ovf",  32'(ref_calc(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'h2_7FFF);
    check("pin_sub_brw",  32'(ref_calc(16'h0003, 16'h0005, 1'b1, 1'b1)), 32'h1_FFFD);
    check("pin_add_cin",  32'(ref_calc(16'h1234, 16'h1111, 1'b1, 1'b0)), 32'h0_2346);

    // Carry ripple through every slice, with latency.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
    wait_out(oc);
    check("lat_wrap", 32'(oc - acc), 32'(ST));
    check("res_wrap", 32'({ovf, cout, sum}), 32'h1_0000);
    @(posedge clk);
    #1;
    idle(3);

    // Back-to-back mixed add/sub beats.
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, acc);
    send(16'h0003, 16'h0005, 1'b1, 1'b1, acc);
    send(16'h0000, 16'h0000, 1'b1, 1'b1, acc);   // 0-0-1: all ones, borrow
    send(16'h8000, 16'h8000, 1'b0, 1'b0, acc);   // negative overflow, carry out
    send(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, acc);   // exactly 2^16
    send(16'h1234, 16'h1234, 1'b0, 1'b1, acc);   // zero, no borrow
    idle(8);

    // Random stream with a three-cycle output stall once results flow.
    lows = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      end
      begin
        for (int r = 0; r < 20; r++) begin
          out_ready = !(r >= 7 && r <= 9);
          @(negedge clk);
          if (!in_ready) lows++;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    check("stall_in_ready_low_cycles", 32'(lows), 32'd3);
    idle(8);

    // Reset with beats in flight, then one fresh beat.
    send(16'h1111, 16'h2222, 1'b0, 1'b0, acc);
    send(16'h3333, 16'h4444, 1'b0, 1'b1, acc);
    send(16'h5555, 16'h6666, 1'b1, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, acc);
    wait_out(oc);
    check("lat_after_rst", 32'(oc - acc), 32'(ST));
    check("res_after_rst", 32'({ovf, cout, sum}), 32'h0_2345);
    @(posedge clk);
    #1;
    idle(6);

    // Drain.
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) idle(1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter SLICE, default 4, bits added per pipeline stage; STAGES = WIDTH/SLICE.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts an operand beat this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (add) or borrow-in (sub).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result beat.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out (add) or borrow-out (sub).
REQ-015 ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-016 WIDTH SHALL be a non-zero multiple of SLICE; elaboration SHALL fail otherwise.
REQ-017 Add: {cout,sum} = a + b + cin, computed mod 2^(WIDTH+1).
REQ-018 Sub: sum = (a - b - cin) mod 2^WIDTH; realised as a + ~b + ~cin; cout = NOT of the final carry, so 1 means borrow.
REQ-019 ovf SHALL be 1 when the operand sign bits (a, and b after inversion for sub) are equal and sum's MSB differs from them.
REQ-020 Pipeline: STAGES registered stages; stage k adds slice k (bits k*SLICE+SLICE-1..k*SLICE) with the carry registered from stage k-1; stage 0 uses the effective carry-in (cin, or ~cin for sub).
REQ-021 Each stage SHALL register its valid bit, the completed lower result slices, the unprocessed upper operand slices, the carry, and the sub flag.
REQ-022 Transfer on input: in_valid && in_ready; transfer on output: out_valid && out_ready.
REQ-023 Global stall: advance = !out_valid || out_ready; in_ready = advance && !rst; when advance = 0, every stage SHALL hold its contents.
REQ-024 When advance = 1, every stage SHALL load from its predecessor; stage 0 SHALL load valid = in_valid.
REQ-025 Latency: a beat accepted at edge N SHALL appear with out_valid = 1 after edge N+STAGES when there is no stall; each stall cycle adds exactly one cycle.
REQ-026 Throughput: one beat per cycle while out_ready = 1; no bubbles inserted, no beats dropped or duplicated, order preserved.
REQ-027 sum, cout and ovf SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-028 Stage bubbles (valid = 0) SHALL propagate; their data is don't-care but SHALL NOT raise out_valid.
REQ-029 sub and cin SHALL be sampled per beat; mixed add/sub beats back-to-back SHALL each compute correctly.
REQ-030 STAGES = 1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-031 With rst = 1 at an edge, all stage valid bits SHALL clear; out_valid = 0, sum = 0, cout = 0, ovf = 0 after that edge.
REQ-032 in_ready SHALL be 0 while rst = 1; beats presented during reset SHALL be discarded.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight beats; the first beat accepted after rst falls SHALL emerge with normal latency.

Verification (WIDTH=16, SLICE=4, latency 4)
REQ-034 Add a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
REQ-035 Add a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1; sub a=0x8000, b=0x0001, cin=0 -> sum=0x7FFF, cout=0, ovf=1.
REQ-036 Sub a=0x0003, b=0x0005, cin=1 -> sum=0xFFFD, cout=1 (borrow), ovf=0.
REQ-037 Stream 8 random beats every cycle with out_ready held 0 for cycles 3-5 -> in_ready=0 for those cycles, outputs held, all 8 results match a reference model in order.
REQ-038 Accept 3 beats, assert rst for 1 cycle, then send a=0x1234, b=0x1111 -> no stale outputs; single result sum=0x2345 exactly 4 cycles after acceptance.
